// File: rtl/capture_pkg.sv
// Shared constants for the trigger capture buffer: FSM encoding, width
// derivations and the parameter legality check used at elaboration.
package capture_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PRE   = 3'd1;
   localparam logic [2:0] ST_ARMED = 3'd2;
   localparam logic [2:0] ST_POST  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // ADDR_W and WORD_W follow from the instance parameters.
   function automatic int calcAddrW(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int calcWordW(input int channels, input int sampleW);
      return channels * sampleW;
   endfunction

   function automatic bit paramsOk(input int depth, input int preTrig);
      return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
             (preTrig >= 1) && (preTrig <= depth - 1);
   endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module capture_ram #(
   parameter int WORD_W = 32,
   parameter int ADDR_W = 8
) (
   input  logic              SysClk,
   input  logic              ResetN,
   input  logic              WrEn,
   input  logic [ADDR_W-1:0] WrAddr,
   input  logic [WORD_W-1:0] WrData,
   input  logic              RdEn,
   input  logic [ADDR_W-1:0] RdAddr,
   output logic [WORD_W-1:0] RdData
);

   logic [WORD_W-1:0] mem [0:(2**ADDR_W)-1];

   always_ff @(posedge SysClk) begin
      if (WrEn) mem[WrAddr] <= WrData;
   end

   // Only the read register is cleared so DataOut reads 0 out of reset.
   always_ff @(posedge SysClk or negedge ResetN) begin
      if (!ResetN)   RdData <= '0;
      else if (RdEn) RdData <= mem[RdAddr];
   end

endmodule

// File: rtl/trig_capture_buffer.sv
// Pre/post-trigger capture buffer: circular recording, edge trigger, then
// paced readout of the oldest retained word onward.
//
//   state | meaning
//   IDLE  | waiting for EnableDataCapture
//   PRE   | filling the PRE_TRIG pre-trigger words, triggers ignored
//   ARMED | circular recording, waiting for a FastTrigger rising edge
//   POST  | recording the remaining post-trigger words
//   DONE  | recording stopped, DataReady high, readout in progress
module trig_capture_buffer
   import capture_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int SAMPLE_W = 8,
   parameter int DEPTH    = 256,
   parameter int PRE_TRIG = 32
) (
   input  logic                                 SysClk,
   input  logic                                 ResetN,
   input  logic [calcWordW(CHANNELS, SAMPLE_W)-1:0] DataIn,
   input  logic                                 FastTrigger,
   input  logic                                 EnableDataCapture,
   input  logic                                 AutoRearm,
   input  logic [calcAddrW(DEPTH)-1:0]          PostCount,
   input  logic                                 RdEn,
   output logic [calcWordW(CHANNELS, SAMPLE_W)-1:0] DataOut,
   output logic                                 DataValid,
   output logic                                 DataReady,
   output logic                                 Armed
);

   localparam int ADDR_W = calcAddrW(DEPTH);
   localparam int WORD_W = calcWordW(CHANNELS, SAMPLE_W);
   localparam int CNT_W  = ADDR_W + 1;

   localparam logic [ADDR_W-1:0] PRE_A  = ADDR_W'(PRE_TRIG);
   localparam logic [ADDR_W-1:0] MAX_PC = ADDR_W'(DEPTH - PRE_TRIG);
   localparam logic [CNT_W-1:0]  PRE_C  = CNT_W'(PRE_TRIG);

   if (!paramsOk(DEPTH, PRE_TRIG)) begin : g_paramCheck
      $error("trig_capture_buffer: DEPTH must be a power of two >= 4, PRE_TRIG in 1..DEPTH-1");
   end

   logic [2:0]        state;
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;
   logic [ADDR_W-1:0] pcLat;
   logic [ADDR_W-1:0] pcClamp;
   logic [ADDR_W-1:0] cnt;
   logic [CNT_W-1:0]  readLeft;
   logic              trigQ;
   logic              trigEdge;
   logic              wrEn;
   logic              ramRd;

   assign trigEdge  = FastTrigger & ~trigQ;
   assign wrEn      = EnableDataCapture &
                      ((state == ST_PRE) || (state == ST_ARMED) || (state == ST_POST));
   assign ramRd     = (state == ST_DONE) && RdEn && (readLeft != '0);
   assign DataReady = (state == ST_DONE);
   assign Armed     = (state == ST_ARMED);

   always_comb begin
      pcClamp = PostCount;
      if (PostCount == '0)         pcClamp = ADDR_W'(1);
      else if (PostCount > MAX_PC) pcClamp = MAX_PC;
   end

   always_ff @(posedge SysClk or negedge ResetN) begin
      if (!ResetN) begin
         state     <= ST_IDLE;
         wptr      <= '0;
         rptr      <= '0;
         pcLat     <= '0;
         cnt       <= '0;
         readLeft  <= '0;
         trigQ     <= 1'b0;
         DataValid <= 1'b0;
      end else begin
         trigQ     <= FastTrigger;
         DataValid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (EnableDataCapture) begin
                  state <= ST_PRE;
                  wptr  <= '0;
                  pcLat <= pcClamp;
                  cnt   <= ADDR_W'(PRE_TRIG - 1);
               end
            end
            ST_PRE: begin
               if (!EnableDataCapture) begin
                  state <= ST_IDLE;
               end else begin
                  wptr <= wptr + 1'b1;
                  if (cnt == '0) state <= ST_ARMED;
                  else           cnt   <= cnt - 1'b1;
               end
            end
            ST_ARMED: begin
               if (!EnableDataCapture) begin
                  state <= ST_IDLE;
               end else begin
                  wptr <= wptr + 1'b1;
                  if (trigEdge) begin
                     // Readout starts PRE_TRIG words before the trigger word.
                     rptr     <= wptr - PRE_A;
                     readLeft <= PRE_C + CNT_W'(pcLat);
                     if (pcLat == ADDR_W'(1)) begin
                        state <= ST_DONE;
                     end else begin
                        state <= ST_POST;
                        cnt   <= pcLat - ADDR_W'(2);
                     end
                  end
               end
            end
            ST_POST: begin
               if (!EnableDataCapture) begin
                  state <= ST_IDLE;
               end else begin
                  wptr <= wptr + 1'b1;
                  if (cnt == '0) state <= ST_DONE;
                  else           cnt   <= cnt - 1'b1;
               end
            end
            ST_DONE: begin
               if (readLeft == '0) begin
                  if (AutoRearm && EnableDataCapture) begin
                     state <= ST_PRE;
                     wptr  <= '0;
                     pcLat <= pcClamp;
                     cnt   <= ADDR_W'(PRE_TRIG - 1);
                  end else begin
                     state <= ST_IDLE;
                  end
               end else if (RdEn) begin
                  rptr      <= rptr + 1'b1;
                  readLeft  <= readLeft - 1'b1;
                  DataValid <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   capture_ram #(
      .WORD_W (WORD_W),
      .ADDR_W (ADDR_W)
   ) uRam (
      .SysClk (SysClk),
      .ResetN (ResetN),
      .WrEn   (wrEn),
      .WrAddr (wptr),
      .WrData (DataIn),
      .RdEn   (ramRd),
      .RdAddr (rptr),
      .RdData (DataOut)
   );

endmodule

// File: tb/tb_trig_capture_buffer.sv
// Scoreboard bench for trig_capture_buffer: a history-based reference model
// queues expected readout words, a negedge monitor compares on DataValid.
module tb_trig_capture_buffer;

   localparam int DEPTH    = 64;
   localparam int PRE_TRIG = 8;
   localparam int HIST     = 16384;

   logic        SysClk = 1'b0;
   logic        ResetN;
   logic [31:0] DataIn;
   logic        FastTrigger;
   logic        EnableDataCapture;
   logic        AutoRearm;
   logic [5:0]  PostCount;
   logic        RdEn;
   logic [31:0] DataOut;
   logic        DataValid;
   logic        DataReady;
   logic        Armed;

   trig_capture_buffer #(
      .CHANNELS (4),
      .SAMPLE_W (8),
      .DEPTH    (DEPTH),
      .PRE_TRIG (PRE_TRIG)
   ) dut (
      .SysClk            (SysClk),
      .ResetN            (ResetN),
      .DataIn            (DataIn),
      .FastTrigger       (FastTrigger),
      .EnableDataCapture (EnableDataCapture),
      .AutoRearm         (AutoRearm),
      .PostCount         (PostCount),
      .RdEn              (RdEn),
      .DataOut           (DataOut),
      .DataValid         (DataValid),
      .DataReady         (DataReady),
      .Armed             (Armed)
   );

   always #5 SysClk = ~SysClk;

   int          nChecks = 0;
   int          nFails  = 0;
   logic [31:0] expQ[$];
   logic [31:0] gotQ[$];
   logic [31:0] hist  [0:HIST-1];
   logic        trigH [0:HIST-1];
   int          cyc = 0;
   logic [7:0]  r = 8'd0;
   bit          randData = 1'b0;
   int          preStart = 0;

   task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: record what the DUT saw this cycle, then advance the ramp.
   task automatic tick();
      if (cyc < HIST) begin
         hist[cyc]  = DataIn;
         trigH[cyc] = FastTrigger;
      end
      @(posedge SysClk);
      #1;
      cyc++;
      r++;
      DataIn = randData ? $urandom : {4{r}};
   endtask

   task automatic armAt(input logic [5:0] pc);
      r                 = 8'hFF;
      DataIn            = randData ? $urandom : {4{r}};
      EnableDataCapture = 1'b1;
      PostCount         = pc;
      preStart          = cyc + 1;
      tick();
   endtask

   task automatic trigAtR(input logic [7:0] t);
      int guard = 0;
      while (r != t && guard < 300) begin
         tick();
         guard++;
      end
      FastTrigger = 1'b1;
      tick();
      FastTrigger = 1'b0;
   endtask

   task automatic waitReady(input string name);
      int n = 0;
      while (!DataReady && n < 400) begin
         tick();
         n++;
      end
      checkEq(name, 32'(DataReady), 32'd1);
   endtask

   function automatic int pcEff(input int pc);
      if (pc == 0) return 1;
      if (pc > DEPTH - PRE_TRIG) return DEPTH - PRE_TRIG;
      return pc;
   endfunction

   // Reference model: the capture is the first trigger rising edge seen once
   // PRE_TRIG words have been recorded; readout is the PRE_TRIG samples before
   // it followed by the effective post count starting at the trigger sample.
   task automatic pushExpected(input int pc, output int nWords);
      int t = -1;
      nWords = 0;
      for (int c = preStart + PRE_TRIG; c < cyc && t < 0; c++)
         if (trigH[c] && !trigH[c-1]) t = c;
      if (t < 0) begin
         nChecks++;
         nFails++;
         $display("FAIL model_trigger: got no trigger edge while armed, expected one");
         return;
      end
      nWords = PRE_TRIG + pcEff(pc);
      for (int k = 0; k < nWords; k++) expQ.push_back(hist[t - PRE_TRIG + k]);
   endtask

   task automatic readOut(input int n, input bit gaps, output int lastRd);
      int issued = 0;
      int guard  = 0;
      lastRd = cyc;
      gotQ.delete();
      while (issued < n && guard < 1000) begin
         RdEn = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (RdEn) begin
            issued++;
            lastRd = cyc;
         end
         tick();
         guard++;
      end
      checkEq("ready_with_last_word", 32'(DataReady), 32'd1);
      RdEn = 1'b1;
      tick();
      checkEq("ready_drop", 32'(DataReady), 32'd0);
      tick();
      RdEn = 1'b0;
      checkEq("word_count", 32'(gotQ.size()), 32'(n));
      checkEq("queue_drained", 32'(expQ.size()), 32'd0);
      expQ.delete();
   endtask

   function automatic logic [31:0] firstGot();
      return (gotQ.size() > 0) ? gotQ[0] : 32'hDEADBEEF;
   endfunction

   function automatic logic [31:0] lastGot();
      return (gotQ.size() > 0) ? gotQ[gotQ.size()-1] : 32'hDEADBEEF;
   endfunction

   always @(negedge SysClk) begin
      if (DataValid) begin
         gotQ.push_back(DataOut);
         if (expQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("FAIL unexpected_valid: got 0x%08h, expected no word", DataOut);
         end else begin
            checkEq("readout_word", DataOut, expQ.pop_front());
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected end within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int lr;
      int pc;
      int len;

      ResetN = 1'b0; DataIn = '0; FastTrigger = 1'b0; EnableDataCapture = 1'b0;
      AutoRearm = 1'b0; PostCount = '0; RdEn = 1'b0;
      repeat (3) @(posedge SysClk);
      #1;
      checkEq("rst_DataValid", 32'(DataValid), 32'd0);
      checkEq("rst_DataReady", 32'(DataReady), 32'd0);
      checkEq("rst_Armed",     32'(Armed),     32'd0);
      checkEq("rst_DataOut",   DataOut,        32'd0);
      ResetN = 1'b1;
      tick();

      // Basic capture
      armAt(6'd16);
      trigAtR(8'd40);
      waitReady("basic_ready");
      EnableDataCapture = 1'b0;
      pushExpected(16, n);
      checkEq("basic_len", 32'(n), 32'd24);
      readOut(n, 1'b1, lr);
      checkEq("basic_first", firstGot(), 32'h20202020);
      checkEq("basic_last",  lastGot(),  32'h37373737);

      // Wraparound of the circular buffer
      armAt(6'd40);
      trigAtR(8'd100);
      waitReady("wrap_ready");
      EnableDataCapture = 1'b0;
      pushExpected(40, n);
      readOut(n, 1'b0, lr);
      checkEq("wrap_count", 32'(gotQ.size()), 32'd48);
      checkEq("wrap_first", firstGot(), 32'h5C5C5C5C);
      checkEq("wrap_last",  lastGot(),  32'h8B8B8B8B);

      // Triggers during PRE, including on its final cycle, are ignored
      armAt(6'd10);
      trigAtR(8'd3);
      trigAtR(8'd7);
      checkEq("early_armed", 32'(Armed), 32'd1);
      repeat (3) tick();
      checkEq("early_still_armed", 32'(Armed), 32'd1);
      trigAtR(8'd20);
      waitReady("early_ready");
      EnableDataCapture = 1'b0;
      pushExpected(10, n);
      readOut(n, 1'b1, lr);
      checkEq("early_first", firstGot(), 32'h0C0C0C0C);

      // Clamp and zero post count
      armAt(6'd63);
      trigAtR(8'd20);
      waitReady("clamp_ready");
      EnableDataCapture = 1'b0;
      pushExpected(63, n);
      readOut(n, 1'b1, lr);
      checkEq("clamp_count", 32'(gotQ.size()), 32'd64);

      armAt(6'd0);
      trigAtR(8'd30);
      waitReady("zero_ready");
      EnableDataCapture = 1'b0;
      pushExpected(0, n);
      readOut(n, 1'b1, lr);
      checkEq("zero_count", 32'(gotQ.size()), 32'd9);
      checkEq("zero_last",  lastGot(), 32'h1E1E1E1E);

      // Abort during POST, then RdEn in IDLE produces nothing
      armAt(6'd30);
      trigAtR(8'd20);
      repeat (3) tick();
      EnableDataCapture = 1'b0;
      tick();
      checkEq("abort_armed", 32'(Armed),     32'd0);
      checkEq("abort_ready", 32'(DataReady), 32'd0);
      RdEn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checkEq("idle_rd_valid", 32'(DataValid), 32'd0);
         checkEq("idle_rd_ready", 32'(DataReady), 32'd0);
      end
      RdEn = 1'b0;

      // Reset mid-readout
      armAt(6'd16);
      trigAtR(8'd40);
      waitReady("rst_mid_ready");
      EnableDataCapture = 1'b0;
      pushExpected(16, n);
      RdEn = 1'b1;
      repeat (5) tick();
      #2;
      ResetN = 1'b0;
      #1;
      checkEq("midrst_DataValid", 32'(DataValid), 32'd0);
      checkEq("midrst_DataReady", 32'(DataReady), 32'd0);
      checkEq("midrst_Armed",     32'(Armed),     32'd0);
      checkEq("midrst_DataOut",   DataOut,        32'd0);
      RdEn = 1'b0;
      expQ.delete();
      tick();
      ResetN = 1'b1;
      tick();
      checkEq("postrst_ready", 32'(DataReady), 32'd0);
      checkEq("postrst_armed", 32'(Armed),     32'd0);

      // Auto rearm with continuous readout
      AutoRearm = 1'b1;
      armAt(6'd12);
      trigAtR(8'd50);
      waitReady("rearm_ready");
      pushExpected(12, n);
      readOut(n, 1'b0, lr);
      preStart = lr + 2;
      while (cyc < lr + 1 + PRE_TRIG) tick();
      checkEq("rearm_not_yet", 32'(Armed), 32'd0);
      tick();
      checkEq("rearm_armed", 32'(Armed), 32'd1);
      AutoRearm = 1'b0;
      trigAtR(r + 8'd5);
      waitReady("rearm2_ready");
      EnableDataCapture = 1'b0;
      pushExpected(12, n);
      readOut(n, 1'b1, lr);

      // Randomized captures: random data, post count, trigger noise, read gaps
      randData = 1'b1;
      for (int it = 0; it < 10; it++) begin
         pc  = $urandom_range(0, 63);
         len = $urandom_range(8, 90);
         armAt(6'(pc));
         for (int k = 0; k < len; k++) begin
            FastTrigger = ($urandom_range(0, 5) == 0);
            tick();
         end
         FastTrigger = 1'b0;
         tick();
         FastTrigger = 1'b1;
         tick();
         FastTrigger = 1'b0;
         waitReady("rand_ready");
         EnableDataCapture = 1'b0;
         pushExpected(pc, n);
         readOut(n, 1'b1, lr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/trig_capture_buffer.md
TRIG_CAPTURE_BUFFER -- requirements
Module: trig_capture_buffer

Interface
REQ-001 Parameter CHANNELS, default 4: number of parallel sample lanes per word.
REQ-002 Parameter SAMPLE_W, default 8: bits per lane sample.
REQ-003 Parameter DEPTH, default 256: buffer words; power of two, at least 4.
REQ-004 Parameter PRE_TRIG, default 32: pre-trigger words retained; range 1..DEPTH-1.
REQ-005 SysClk  input  1  sole clock; all logic on the rising edge.
REQ-006 ResetN  input  1  asynchronous, active-low reset.
REQ-007 DataIn  input  CHANNELS*SAMPLE_W  sample word, one per cycle; lane 0 in the LSBs.
REQ-008 FastTrigger  input  1  trigger request; the block acts on its rising edge.
REQ-009 EnableDataCapture  input  1  arm request; low aborts capture.
REQ-010 AutoRearm  input  1  1 = return to PRE after readout; 0 = return to IDLE.
REQ-011 PostCount  input  log2(DEPTH)  post-trigger words, including the trigger word; latched on entry to PRE.
REQ-012 RdEn  input  1  readout request, one word per asserted cycle.
REQ-013 DataOut  output  CHANNELS*SAMPLE_W  readout word.
REQ-014 DataValid  output  1  DataOut is valid this cycle.
REQ-015 DataReady  output  1  capture complete; readout is allowed.
REQ-016 Armed  output  1  high in the ARMED state only.

Function
REQ-017 States are IDLE, PRE, ARMED, POST and DONE; encodings are defined in the package.
REQ-018 IDLE -> PRE when EnableDataCapture=1; the write pointer clears and PostCount is latched as PC.
REQ-019 PRE, ARMED and POST write DataIn to RAM[wptr] every cycle; wptr increments modulo DEPTH.
REQ-020 PRE -> ARMED after exactly PRE_TRIG writes; FastTrigger edges during PRE are ignored.
REQ-021 ARMED writes circularly with wraparound; a rising edge of FastTrigger -> POST, and the word written in that cycle is recorded as the trigger word at address taddr.
REQ-022 POST -> DONE once PC words (the trigger word included) have been written; PC=0 is treated as 1, and PC>DEPTH-PRE_TRIG is clamped to DEPTH-PRE_TRIG.
REQ-023 In DONE, DataReady=1 and writes stop; the read pointer starts at taddr-PRE_TRIG modulo DEPTH (the oldest retained word).
REQ-024 Readout latency is 1: if RdEn is high in cycle n, then DataOut and DataValid=1 are presented in cycle n+1, and the read pointer increments modulo DEPTH.
REQ-025 Total readout length is PRE_TRIG+PC words; RdEn beyond that count is ignored (no DataValid).
REQ-026 After the final word is issued, DataReady drops in the following cycle; next state is PRE if AutoRearm=1 and EnableDataCapture=1, otherwise IDLE.
REQ-027 RdEn outside DONE is ignored and DataValid stays 0.
REQ-028 EnableDataCapture=0 in PRE, ARMED or POST -> IDLE next cycle; the capture is discarded and DataReady stays 0.
REQ-029 EnableDataCapture=0 in DONE does not abort readout; after the last word the next state is IDLE.
REQ-030 A FastTrigger rising edge in the same cycle that PRE completes is ignored; a trigger requires state ARMED.
REQ-031 Trigger edge detection uses a one-flop delay of FastTrigger; a trigger held high produces only one event.

Reset
REQ-032 ResetN low asynchronously forces state IDLE, all pointers and counters to 0, DataValid=0, DataReady=0, Armed=0, DataOut=0, and the trigger delay flop to 0.
REQ-033 RAM contents are not reset; no output depends on unwritten RAM.
REQ-034 Assertion of ResetN mid-capture or mid-readout discards the capture; release resumes in IDLE.

Structure
REQ-035 Package capture_pkg holds the state encoding and the derived constants ADDR_W=log2(DEPTH) and WORD_W=CHANNELS*SAMPLE_W.
REQ-036 Storage is one sub-module, capture_ram: simple dual-port, synchronous read, one write port and one read port, both on SysClk.
REQ-037 Control, pointers and counters reside in trig_capture_buffer; the package also provides an elaboration-time check of REQ-003 and REQ-004.

Verification
Bench configuration: CHANNELS=4, SAMPLE_W=8, DEPTH=64, PRE_TRIG=8. DataIn is the ramp byte r replicated in all four lanes.
REQ-038 Basic capture: PostCount=16, trigger pulse when r=40 -> DataReady=1 and 24 words read; first word 0x20202020, last word 0x37373737, and the DataReady drop follows.
REQ-039 Wrap: PostCount=40, trigger when r=100 -> 48 words reading r=92..139 contiguous across the wrap of address 63->0.
REQ-040 Early trigger: trigger at r=3 (during PRE) -> ignored and state remains ARMED; a second trigger at r=20 -> first word read is r=12.
REQ-041 Clamp and zero: PostCount=63 -> 64 words read; PostCount=0 -> 9 words read, last word equal to the trigger word.
REQ-042 Abort and reset: EnableDataCapture dropped in POST -> IDLE with DataReady=0; ResetN pulsed low mid-readout -> all outputs 0 immediately.
REQ-043 AutoRearm=1 with continuous RdEn -> after the final word, Armed rises again after PRE_TRIG+1 cycles; RdEn held high in IDLE -> DataValid remains 0.
